rr_mux_arbiter: RTL
===================

// Module: rr_mux_arbiter
// PURPOSE
//  Round-robin arbiter sharing the 16:1 bit mux (sixtoone) among 16 requesters.
//  Picks one requester, drives the mux select, holds it until released or timed out.
//  Registered sel[3:0] wires straight to the mux s input; the mux's f goes to the consumer.
// PARAMETERS
//  N_REQ     16  number of requesters; fixed by the mux width, not for override
//  SEL_W      4  select width, log2(N_REQ)
//  MAX_HOLD   8  maximum cycles a grant may be held (must be >=1)
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous reset, active low
//  en      in   1      enables new grants; an active grant still completes when en=0
//  req     in   16     request vector, bit i = requester i
//  done    in   1      consumer finished with current channel; releases grant
//  sel     out  4      mux select, stable for the whole grant
//  grant   out  16     one-hot grant, bit sel set while valid
//  valid   out  1      sel/grant currently meaningful
//  ptr     out  4      round-robin pointer (next highest-priority index), for debug
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, sel=0, grant=0, valid=0, ptr=0, hold_cnt=0.
//  All outputs are registered. No combinational path from req or done to outputs.
//  States:
//   IDLE:  if en && |req, pick first set bit scanning ptr, ptr+1, ... , 15, 0, ... ptr-1.
//          Next cycle: sel=idx, grant=1<<idx, valid=1, hold_cnt=0, state=GRANT.
//          Latency is 1 clk from req sampled to valid.
//   GRANT: sel and grant are held constant. hold_cnt increments each cycle.
//          Release when any of the following is true: done=1; req[sel]=0;
//          hold_cnt==MAX_HOLD-1.
//          On release, next cycle: valid=0, grant=0, sel holds its last value,
//          ptr=sel+1 mod 16 (15 wraps to 0), state=IDLE.
//  Spacing: a release always gives exactly one valid=0 cycle before the next grant.
//  Fairness: a continuously requesting channel waits at most 15 grants.
//  Simultaneous release causes (e.g. done with timeout) give one release and one ptr advance.
//  done in IDLE is ignored. Changes to other req bits during GRANT are ignored.
//  en=0 in IDLE: stay in IDLE and ptr does not change. en falling during GRANT does not
//  cut the grant short.
//  req==0 in IDLE: stay in IDLE with valid=0.
//  MAX_HOLD=1: release after exactly one valid cycle.
//  rst_n asserted mid-grant: outputs clear at once (asynchronous), and the pending
//  release does not advance ptr.
//  hold_cnt width is clog2(MAX_HOLD)+1. It saturates and never wraps.
// STRUCTURE
//  Shared package mux_ctrl_pkg holds:
//   - the state encoding localparams (ST_IDLE=0, ST_GRANT=1)
//   - MUX_N=16 and MUX_SEL_W=4, also used by the mux wrapper
//  Sub-module rr_pick: purely combinational.
//   - inputs req[15:0] and ptr[3:0]; outputs idx[3:0] and found.
//   - implement it by rotating req right by ptr, priority-encoding, then adding ptr back mod 16.
//  Top level holds the FSM, ptr, hold_cnt and the output registers.
// TESTING
//  1 Reset then req=16'h0001, en=1: next clk sel=0, grant=0001, valid=1. Then done=1:
//    next clk valid=0, ptr=1.
//  2 req=16'hFFFF held, done never asserted, MAX_HOLD=8: grants go 0,1,2,...,15,0.
//    Each lasts 8 cycles with one valid=0 gap between grants.
//  3 Wrap-around: ptr=15, req=16'h8001: grant 15 first, then 0 (not 0 twice).
//    ptr goes 15->0->1.
//  4 During grant on ch 3 raise req=16'h0010 and drop req[3]: release next clk,
//    then grant ch 4 after one gap cycle.
//  5 en=0 while req=16'h0100: valid stays 0 and ptr is unchanged. Drop en during an active
//    grant: that grant finishes on done.
//  6 Pull rst_n low mid-grant (not clock-aligned): sel=0, grant=0, valid=0, ptr=0
//    immediately. After release of reset, req=16'h0004 gives grant ch 2.
//  Bench checks every cycle: grant==(valid ? 1<<sel : 0), and the mux output f equals
//  data[sel] whenever valid=1.

Source files
------------

// File: rtl/mux_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mux_ctrl_pkg                                                 |
// | Description : Shared constants and FSM state encoding for the round-robin  |
// |               arbiter and the 16:1 bit mux it controls.                    |
// |               MUX_N     - number of mux inputs / requesters                |
// |               MUX_SEL_W - mux select width                                 |
// |               state_t   - arbiter FSM states (ST_IDLE=0, ST_GRANT=1)       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mux_ctrl_pkg;

  localparam int MUX_N     = 16;
  localparam int MUX_SEL_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_pick                                                      |
// | Description : Combinational round-robin picker. Returns the first set bit  |
// |               of req scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1.          |
// |   req    in  16  request vector                                            |
// |   ptr    in   4  highest-priority index                                    |
// |   idx    out  4  chosen requester (valid only when found=1)                |
// |   found  out  1  at least one request is set                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rr_pick
  import mux_ctrl_pkg::*;
(
  input  logic [MUX_N-1:0]     req,
  input  logic [MUX_SEL_W-1:0] ptr,
  output logic [MUX_SEL_W-1:0] idx,
  output logic                 found
);

  logic [MUX_N-1:0]     req_rot;
  logic [MUX_SEL_W-1:0] off;

  always_comb begin
    // Rotating right by ptr puts requester ptr at bit 0, so the lowest set bit
    // of req_rot is the round-robin winner's offset from ptr.
    req_rot = MUX_N'({req, req} >> ptr);
    off     = '0;
    // Scan downward so the last hit (lowest index) wins.
    for (int i = MUX_N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off = MUX_SEL_W'(i);
      end
    end
    found = |req;
    // Adding ptr back wraps naturally in the 4-bit result.
    idx   = off + ptr;
  end

endmodule
`default_nettype wire

// File: rtl/sixtoone.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sixtoone                                                     |
// | Description : 16:1 single-bit multiplexer shared by the arbiter's clients. |
// |   d  in  16  data inputs, bit i from requester i                           |
// |   s  in   4  select (driven by the arbiter's registered sel)               |
// |   f  out  1  selected bit, d[s]                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sixtoone
  import mux_ctrl_pkg::*;
(
  input  logic [MUX_N-1:0]     d,
  input  logic [MUX_SEL_W-1:0] s,
  output logic                 f
);

  assign f = d[s];

endmodule
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_mux_arbiter                                               |
// | Description : Round-robin arbiter sharing a 16:1 bit mux among 16          |
// |               requesters. A grant is held until done, until the granted    |
// |               request drops, or until MAX_HOLD cycles have elapsed.        |
// |   clk    in   1  rising-edge clock                                         |
// |   rst_n  in   1  asynchronous reset, active low                            |
// |   en     in   1  enables new grants (an active grant always completes)     |
// |   req    in  16  request vector                                            |
// |   done   in   1  consumer finished, releases the current grant             |
// |   sel    out  4  mux select, stable for the whole grant                    |
// |   grant  out 16  one-hot grant, bit sel set while valid                    |
// |   valid  out  1  sel/grant meaningful                                      |
// |   ptr    out  4  round-robin pointer (next highest-priority index)         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rr_mux_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [MUX_N-1:0]     req,
  input  logic                 done,
  output logic [MUX_SEL_W-1:0] sel,
  output logic [MUX_N-1:0]     grant,
  output logic                 valid,
  output logic [MUX_SEL_W-1:0] ptr
);

  localparam int N_REQ  = MUX_N;
  localparam int SEL_W  = MUX_SEL_W;
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;
  logic               rel;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    // Any release cause collapses into one release, hence one ptr advance.
    rel     = done || !req[sel_q] || (hold_q == HOLD_LAST);

    case (state_q)
      ST_IDLE: begin
        if (en && pick_found) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx;
          grant_d = N_REQ'(1) << pick_idx;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (rel) begin
          // sel keeps its last value; only valid/grant drop.
          state_d = ST_IDLE;
          grant_d = '0;
          valid_d = 1'b0;
          ptr_d   = sel_q + SEL_W'(1);
        end else if (hold_q != HOLD_SAT) begin
          hold_d  = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign valid = valid_q;
  assign ptr   = ptr_q;

endmodule
`default_nettype wire
